// File: rtl/mac_reset_ctrl.sv
// MAC reset/bus-integration controller: holds MAC components in reset, waits for
// bus idle before enabling, and tracks the bus-off recovery sequence.
module mac_reset_ctrl #(
    parameter int HOLD_TICKS = 4,
    parameter int IDLE_BITS  = 11,
    parameter int RECOV_SEQ  = 128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       prescaler,
    input  logic       rx_bit,
    input  logic       sw_reset_req,
    input  logic       busoff,
    output logic       sync_reset,
    output logic       mac_enable,
    output logic [1:0] state_o,
    output logic [6:0] recov_cnt
);

    localparam int BW = (IDLE_BITS > 1) ? $clog2(IDLE_BITS + 1) : 1;
    localparam logic [3:0]    HOLD_LAST = 4'(HOLD_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(IDLE_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [6:0]    SEQ_LAST  = 7'(RECOV_SEQ - 1);

    typedef enum logic [1:0] {
        S_HOLD   = 2'b00,
        S_INTEG  = 2'b01,
        S_RUN    = 2'b10,
        S_BUSOFF = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    hold_q, hold_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [6:0]    seq_q, seq_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_HOLD;
            hold_q  <= '0;
            bit_q   <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            bit_q   <= bit_d;
            seq_q   <= seq_d;
        end
    end

    // Terminal counts use >= so a counter can never run past its limit and wrap.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        bit_d   = bit_q;
        seq_d   = seq_q;
        if (sw_reset_req) begin
            state_d = S_HOLD;
            hold_d  = '0;
            bit_d   = '0;
            seq_d   = '0;
        end else begin
            case (state_q)
                S_HOLD: if (prescaler) begin
                    if (hold_q >= HOLD_LAST) begin
                        state_d = S_INTEG;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
                S_INTEG: if (prescaler) begin
                    if (!rx_bit) begin
                        bit_d = '0;
                    end else if (bit_q >= BIT_LAST) begin
                        state_d = S_RUN;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end
                S_RUN: if (busoff) begin
                    state_d = S_BUSOFF;
                    bit_d   = '0;
                    seq_d   = '0;
                end
                S_BUSOFF: if (prescaler) begin
                    if (!rx_bit) begin
                        bit_d = '0;
                    end else if (bit_q >= BIT_LAST) begin
                        bit_d = '0;
                        if (seq_q >= SEQ_LAST) begin
                            state_d = S_HOLD;
                            seq_d   = '0;
                        end else begin
                            seq_d = seq_q + 7'd1;
                        end
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end
                default: state_d = S_HOLD;
            endcase
        end
    end

    // sync_reset also follows the raw reset pin so it drops without waiting for a clock.
    assign sync_reset = reset & (state_q != S_HOLD);
    assign mac_enable = (state_q == S_RUN);
    assign state_o    = state_q;
    assign recov_cnt  = seq_q;

endmodule

// File: tb/tb_mac_reset_ctrl.sv
// Randomized bench for mac_reset_ctrl against a tick-level behavioural model.
module tb_mac_reset_ctrl;
    localparam int HOLD_TICKS = 4;
    localparam int IDLE_BITS  = 11;
    localparam int RECOV_SEQ  = 128;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       prescaler = 1'b0, rx_bit = 1'b1, sw_reset_req = 1'b0, busoff = 1'b0;
    logic       sync_reset, mac_enable;
    logic [1:0] state_o;
    logic [6:0] recov_cnt;

    int vectors = 0;
    int miscompares = 0;

    // model: 0 HOLD, 1 INTEGRATE, 2 RUN, 3 BUSOFF
    int m_st = 0, m_hold = 0, m_run = 0, m_seq = 0;

    always #5 clock = ~clock;

    mac_reset_ctrl #(.HOLD_TICKS(HOLD_TICKS), .IDLE_BITS(IDLE_BITS), .RECOV_SEQ(RECOV_SEQ)) dut (
        .clock(clock), .reset(reset), .prescaler(prescaler), .rx_bit(rx_bit),
        .sw_reset_req(sw_reset_req), .busoff(busoff), .sync_reset(sync_reset),
        .mac_enable(mac_enable), .state_o(state_o), .recov_cnt(recov_cnt)
    );

    function automatic void model_reset();
        m_st = 0; m_hold = 0; m_run = 0; m_seq = 0;
    endfunction

    function automatic void model_clock(bit pre, bit rx, bit sw, bit bo);
        if (sw) begin
            model_reset();
            return;
        end
        case (m_st)
            0: if (pre) begin
                m_hold++;
                if (m_hold == HOLD_TICKS) begin m_st = 1; m_hold = 0; end
            end
            1: if (pre) begin
                if (!rx) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == IDLE_BITS) begin m_st = 2; m_run = 0; end
                end
            end
            2: if (bo) begin m_st = 3; m_run = 0; m_seq = 0; end
            default: if (pre) begin
                if (!rx) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == IDLE_BITS) begin
                        m_run = 0;
                        m_seq++;
                        if (m_seq == RECOV_SEQ) begin m_st = 0; m_seq = 0; end
                    end
                end
            end
        endcase
    endfunction

    function automatic logic [10:0] expect_vec();
        return {(reset && (m_st != 0)), (m_st == 2), 2'(m_st), 7'(m_seq)};
    endfunction

    task automatic step(input bit pre, input bit rx, input bit sw, input bit bo);
        prescaler = pre; rx_bit = rx; sw_reset_req = sw; busoff = bo;
        @(posedge clock);
        if (!reset) model_reset();
        else model_clock(pre, rx, sw, bo);
        @(negedge clock);
    endtask

    // one bit time: a tick clock then three idle clocks with junk on rx_bit
    task automatic tick(input bit rx, input bit bo);
        step(1'b1, rx, 1'b0, bo);
        for (int k = 0; k < 3; k++) step(1'b0, ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, ($urandom_range(0, 1) == 1));
            vectors++;
            if ({sync_reset, mac_enable, state_o, recov_cnt} !== 11'b0) begin
                miscompares++;
                $display("FAIL reset_state: got %b required %b", {sync_reset, mac_enable, state_o, recov_cnt}, 11'b0);
            end
        end
    endtask

    task automatic test_startup();
        int low_ticks = 0;
        reset = 1'b1;
        for (int i = 0; i < HOLD_TICKS + IDLE_BITS; i++) begin
            if (sync_reset === 1'b0) low_ticks++;
            tick(1'b1, 1'b0);
            vectors++;
            if ({sync_reset, mac_enable, state_o, recov_cnt} !== expect_vec()) begin
                miscompares++;
                $display("FAIL startup tick %0d: got %b required %b", i, {sync_reset, mac_enable, state_o, recov_cnt}, expect_vec());
            end
        end
        vectors++;
        if (low_ticks != HOLD_TICKS || state_o !== 2'b10 || mac_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL startup_end: low_ticks %0d state %b en %b required %0d 10 1", low_ticks, state_o, mac_enable, HOLD_TICKS);
        end
    endtask

    task automatic test_integrate_dominant();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < HOLD_TICKS; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < IDLE_BITS - 1; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < IDLE_BITS; i++) begin
            vectors++;
            if (state_o !== 2'b01 || {sync_reset, mac_enable, state_o, recov_cnt} !== expect_vec()) begin
                miscompares++;
                $display("FAIL integ_dominant rec %0d: got %b required state 01 vec %b", i, {sync_reset, mac_enable, state_o, recov_cnt}, expect_vec());
            end
            tick(1'b1, 1'b0);
        end
        vectors++;
        if (state_o !== 2'b10 || mac_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL integ_dominant_run: state %b en %b required 10 1", state_o, mac_enable);
        end
    endtask

    task automatic test_busoff_recovery();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        vectors++;
        if ({sync_reset, mac_enable, state_o, recov_cnt} !== {1'b1, 1'b0, 2'b11, 7'd0}) begin
            miscompares++;
            $display("FAIL busoff_entry: got %b required %b", {sync_reset, mac_enable, state_o, recov_cnt}, {1'b1, 1'b0, 2'b11, 7'd0});
        end
        for (int s = 0; s < RECOV_SEQ; s++) begin
            if (s == 5) begin
                for (int i = 0; i < 6; i++) tick(1'b1, ($urandom_range(0, 1) == 1));
                tick(1'b0, 1'b1);
            end
            for (int i = 0; i < IDLE_BITS; i++) begin
                tick(1'b1, ($urandom_range(0, 1) == 1));
                vectors++;
                if ({sync_reset, mac_enable, state_o, recov_cnt} !== expect_vec()) begin
                    miscompares++;
                    $display("FAIL busoff seq %0d bit %0d: got %b required %b", s, i, {sync_reset, mac_enable, state_o, recov_cnt}, expect_vec());
                end
            end
            vectors++;
            if (recov_cnt !== ((s == RECOV_SEQ - 1) ? 7'd0 : 7'(s + 1)) ||
                state_o !== ((s == RECOV_SEQ - 1) ? 2'b00 : 2'b11)) begin
                miscompares++;
                $display("FAIL busoff_seq_end %0d: recov %0d state %b", s, recov_cnt, state_o);
            end
        end
        for (int i = 0; i < HOLD_TICKS + IDLE_BITS; i++) tick(1'b1, 1'b0);
        vectors++;
        if (state_o !== 2'b10 || mac_enable !== 1'b1 || sync_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL busoff_restart: state %b en %b sync %b required 10 1 1", state_o, mac_enable, sync_reset);
        end
    endtask

    task automatic test_sw_busoff_collision();
        step(1'b0, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (state_o !== 2'b00 || recov_cnt !== 7'd0 || {sync_reset, mac_enable, state_o, recov_cnt} !== expect_vec()) begin
            miscompares++;
            $display("FAIL sw_busoff_collision: state %b recov %0d required 00 0", state_o, recov_cnt);
        end
    endtask

    task automatic test_sw_in_hold();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= HOLD_TICKS; i++) begin
            vectors++;
            if (sync_reset !== 1'b0) begin
                miscompares++;
                $display("FAIL sw_hold_low tick %0d: sync %b required 0", i, sync_reset);
            end
            tick(1'b1, 1'b0);
        end
        vectors++;
        if (state_o !== 2'b01 || {sync_reset, mac_enable, state_o, recov_cnt} !== expect_vec()) begin
            miscompares++;
            $display("FAIL sw_hold_exit: state %b required 01", state_o);
        end
    endtask

    task automatic test_async_reset_busoff();
        for (int i = 0; i < IDLE_BITS; i++) tick(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 60 * IDLE_BITS; i++) tick(1'b1, 1'b0);
        vectors++;
        if (recov_cnt !== 7'd60 || state_o !== 2'b11 || sync_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL busoff_60: recov %0d state %b sync %b required 60 11 1", recov_cnt, state_o, sync_reset);
        end
        #2 reset = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({sync_reset, mac_enable, state_o, recov_cnt} !== 11'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %b required %b", {sync_reset, mac_enable, state_o, recov_cnt}, 11'b0);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i <= HOLD_TICKS; i++) begin
            tick(1'b1, 1'b0);
            vectors++;
            if (state_o !== ((i == HOLD_TICKS) ? 2'b01 : 2'b00)) begin
                miscompares++;
                $display("FAIL post_reset_hold tick %0d: state %b", i, state_o);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0));
            vectors++;
            if ({sync_reset, mac_enable, state_o, recov_cnt} !== expect_vec()) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %b required %b", i, {sync_reset, mac_enable, state_o, recov_cnt}, expect_vec());
            end
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_startup();
        test_integrate_dominant();
        test_busoff_recovery();
        test_sw_busoff_collision();
        test_sw_in_hold();
        test_async_reset_busoff();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
